// File: rtl/memory_bidi_pkg.sv
// -----------------------------------------------------------------------------
// memory_bidi_pkg
// Shared constants for the wait-state memory on the bidirectional data bus:
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - read_write polarity
//   - wait counter width
// -----------------------------------------------------------------------------
package memory_bidi_pkg;

  // Counter width is 4 bits, so WAIT_STATES can be 0..15.
  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Index width for a storage array of the given depth. A depth of 1 still
  // needs a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/memory_bidi_array.sv
// -----------------------------------------------------------------------------
// memory_bidi_array
// Word storage for memory_bidi_wait. Writes are synchronous and masked per
// byte lane. Reads are combinational. Contents are never cleared.
// Ports:
//   clk       in   rising-edge clock
//   wr_en     in   commit wr_data into wr_idx on this edge
//   wr_idx    in   write word index
//   wr_data   in   write data
//   wr_lanes  in   byte-lane mask; lane l covers bits [8l+7:8l]
//   rd_idx    in   read word index
//   rd_data   out  mem[rd_idx]
// -----------------------------------------------------------------------------
module memory_bidi_array
  import memory_bidi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  localparam int IDX_W     = idx_width(DEPTH),
  localparam int LANES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [LANES-1:0]      wr_lanes,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_lanes[l]) begin
          mem[wr_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/memory_bidi_wait.sv
// -----------------------------------------------------------------------------
// memory_bidi_wait
// Single-port RAM on a shared bidirectional data bus with programmable wait
// states, a one-cycle ready pulse, byte-lane write enables and out-of-range
// fault reporting.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for enable; request fields latched on accept
// WAIT  | counting down wait states; leaves when the counter reads 1
// RESP  | one cycle: ready (and fault) high, read data driven, write commits
//
// Ports:
//   clk         in     rising-edge clock
//   reset       in     synchronous, active-high
//   enable      in     request valid; looked at only in IDLE
//   read_write  in     1 = read, 0 = write
//   address     in     word address (never truncated; >= DEPTH is a fault)
//   byte_en     in     write lane enables
//   data        inout  shared bus; driven by this block only in a read RESP
//   ready       out    one-cycle transfer-complete pulse
//   fault       out    with ready when the latched address was out of range
// -----------------------------------------------------------------------------
module memory_bidi_wait
  import memory_bidi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    read_write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  inout  wire  [DATA_WIDTH-1:0]   data,
  output logic                    ready,
  output logic                    fault
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  localparam logic [CNT_W-1:0]    WAIT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]    CNT_TC    = CNT_W'(1);
  // One extra bit so a DEPTH equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  rw_q;
  logic                  oor_q;
  logic [IDX_W-1:0]      idx_q;
  logic [LANES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  addr_oor;
  logic                  in_resp;
  logic                  wr_en;
  logic                  rd_drive;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rd_bus;

  // Full-width compare: an address above DEPTH never aliases onto a low word.
  assign addr_oor = ({1'b0, address} >= DEPTH_CMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_READ;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            rw_q  <= read_write;
            oor_q <= addr_oor;
            idx_q <= address[IDX_W-1:0];
            be_q  <= byte_en;
            if (read_write == RW_WRITE) begin
              wdata_q <= data;
            end
            cnt_q   <= WAIT_LOAD;
            state_q <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_TC) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_resp = (state_q == ST_RESP);

  // Write commits on the edge that ends RESP. Reset on that same edge wins,
  // so an aborted write never reaches the array.
  assign wr_en = in_resp && (rw_q == RW_WRITE) && !oor_q && !reset;

  memory_bidi_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_data  (wdata_q),
    .wr_lanes (be_q),
    .rd_idx   (idx_q),
    .rd_data  (rd_data)
  );

  // Out-of-range reads return zeros rather than whatever the truncated
  // index happens to select.
  assign rd_bus   = oor_q ? '0 : rd_data;
  assign rd_drive = in_resp && (rw_q == RW_READ);
  assign data     = rd_drive ? rd_bus : 'z;

  assign ready = in_resp;
  assign fault = in_resp && oor_q;

endmodule

// File: tb/tb_memory_bidi_wait.sv
module tb_memory_bidi_wait;

  localparam int DEPTH = 1024;
  localparam bit RD = 1'b1;
  localparam bit WR = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  en;
  logic [1:0]  rw;
  logic [1:0]  drv;
  logic [15:0] addr [2];
  logic [15:0] wd   [2];
  logic [1:0]  be   [2];
  wire  [1:0]  rdy;
  wire  [1:0]  flt;

  // Pulled-up buses: an undriven bus reads all-ones, so any stray drive by
  // the memory outside a read response shows up as a changed value.
  tri1  [15:0] bus0;
  tri1  [15:0] bus1;
  assign bus0 = drv[0] ? wd[0] : 16'hzzzz;
  assign bus1 = drv[1] ? wd[1] : 16'hzzzz;

  memory_bidi_wait #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .WAIT_STATES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .read_write(rw[0]), .address(addr[0]),
    .byte_en(be[0]), .data(bus0), .ready(rdy[0]), .fault(flt[0]));

  memory_bidi_wait #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .WAIT_STATES(0)) dut1 (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .read_write(rw[1]), .address(addr[1]),
    .byte_en(be[1]), .data(bus1), .ready(rdy[1]), .fault(flt[1]));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                         input logic [1:0] b);
    logic [15:0] r;
    r = o;
    if (b[0]) r[7:0]  = d[7:0];
    if (b[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Edge counter: after posedge k, cyc == k.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
  end

  // Transaction-level model: a request accepted on edge a finishes with ready
  // visible after edge a+WS, commits on edge a+WS+1, and the next request can
  // be accepted on edge a+WS+2.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int WS = (g == 0) ? 2 : 0;
    int          commit_e = 0;
    int          free_e   = 0;
    bit          pend     = 1'b0;
    bit          m_rw     = 1'b0;
    int          m_addr   = 0;
    logic [1:0]  m_be     = 2'b00;
    logic [15:0] m_wd     = 16'h0;
    logic [15:0] mm [0:DEPTH-1];
    bit          mv [0:DEPTH-1];
    int          rdy_cnt  = 0;
    wire  [15:0] busv = (g == 0) ? bus0 : bus1;

    always @(posedge clk) begin
      if (rst[g]) begin
        pend   <= 1'b0;
        free_e <= cyc + 2;
      end else if (pend) begin
        if (cyc + 1 == commit_e) begin
          pend <= 1'b0;
          if (!m_rw && m_addr < DEPTH) begin
            mm[m_addr] <= merge(mv[m_addr] ? mm[m_addr] : 16'h0, m_wd, m_be);
            mv[m_addr] <= 1'b1;
          end
        end
      end else if (en[g] && cyc + 1 >= free_e) begin
        pend     <= 1'b1;
        m_rw     <= rw[g];
        m_addr   <= int'(addr[g]);
        m_be     <= be[g];
        m_wd     <= wd[g];
        commit_e <= cyc + 1 + WS + 1;
        free_e   <= cyc + 1 + WS + 2;
      end
    end

    always @(negedge clk) begin
      logic        er;
      logic [15:0] eb;
      bit          known;
      if (started) begin
        er = pend && (cyc == commit_e - 1);
        chk($sformatf("ready_u%0d", g), rdy[g], er);
        chk($sformatf("fault_u%0d", g), flt[g], er && (m_addr >= DEPTH));
        if (rdy[g]) rdy_cnt++;
        if (!drv[g]) begin
          known = 1'b1;
          eb    = 16'hFFFF;
          if (er && m_rw) begin
            if (m_addr >= DEPTH)  eb = 16'h0000;
            else if (mv[m_addr])  eb = mm[m_addr];
            else                  known = 1'b0;
          end
          if (known) chk($sformatf("bus_u%0d", g), busv, eb);
        end
      end
    end
  end

  function automatic logic [15:0] bus_of(input int i);
    return (i == 0) ? bus0 : bus1;
  endfunction

  // Called at negedge+1. Holds enable until ready, then releases; returns the
  // ready cycle and the latency measured from the cycle enable was raised.
  task automatic req(input int i, input bit idle_first, input bit r, input logic [15:0] a,
                     input logic [1:0] b, input logic [15:0] d, output logic [15:0] q,
                     output bit f, output int lat, output int rc);
    bit got;
    int t0;
    got = 1'b0;
    if (idle_first) begin
      @(negedge clk); #1;
    end
    en[i] = 1'b1; rw[i] = r; addr[i] = a; be[i] = b; wd[i] = d; drv[i] = ~r;
    t0 = cyc; rc = -1; lat = -1; q = 16'h0; f = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); #1;
      if (rdy[i]) begin
        got = 1'b1; q = bus_of(i); f = flt[i]; rc = cyc; lat = cyc - t0;
      end
    end
    en[i] = 1'b0; drv[i] = 1'b0;
    chk($sformatf("req_done_u%0d_a%0h", i, a), got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] q;
    bit          f;
    int          lat, rc, rc_prev, n0;
    bit          seen;

    rst = 2'b11; en = 2'b00; rw = 2'b00; drv = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 16'h0; wd[i] = 16'h0; be[i] = 2'b00;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready_u0", rdy[0], 1'b0);
    chk("reset_bus_u0", bus0, 16'hFFFF);
    rst = 2'b00;

    // 1: defaults, write then back-to-back read
    req(0, 1, WR, 16'd5, 2'b11, 16'hBEEF, q, f, lat, rc);
    chk("t1_wr_latency", lat, 3);
    chk("t1_wr_fault", f, 1'b0);
    rc_prev = rc;
    req(0, 0, RD, 16'd5, 2'b00, 16'h0, q, f, lat, rc);
    chk("t1_rd_data", q, 16'hBEEF);
    chk("t1_spacing", rc - rc_prev, 4);

    // 2: byte lanes
    req(0, 1, WR, 16'd7, 2'b11, 16'h1234, q, f, lat, rc);
    req(0, 0, WR, 16'd7, 2'b10, 16'hAB00, q, f, lat, rc);
    req(0, 0, RD, 16'd7, 2'b00, 16'h0, q, f, lat, rc);
    chk("t2_lanes", q, 16'hAB34);

    // 3: zero wait states
    req(1, 1, WR, 16'd0, 2'b11, 16'hC0DE, q, f, lat, rc);
    chk("t3_wr_latency", lat, 1);
    rc_prev = rc;
    req(1, 0, RD, 16'd0, 2'b00, 16'h0, q, f, lat, rc);
    chk("t3_rd_data", q, 16'hC0DE);
    chk("t3_spacing", rc - rc_prev, 2);

    // 4: out of range, no aliasing onto word 0
    req(0, 1, WR, 16'd0, 2'b11, 16'h0A0A, q, f, lat, rc);
    req(0, 0, WR, 16'd1024, 2'b11, 16'h5555, q, f, lat, rc);
    chk("t4_wr_fault", f, 1'b1);
    req(0, 0, RD, 16'd1024, 2'b00, 16'h0, q, f, lat, rc);
    chk("t4_rd_zero", q, 16'h0000);
    chk("t4_rd_fault", f, 1'b1);
    req(0, 1, RD, 16'd0, 2'b00, 16'h0, q, f, lat, rc);
    chk("t4_word0", q, 16'h0A0A);
    chk("t4_word0_fault", f, 1'b0);
    req(0, 0, RD, 16'd5, 2'b00, 16'h0, q, f, lat, rc);
    chk("t4_word5", q, 16'hBEEF);

    // 5: enable held with a changing address while busy
    req(0, 1, WR, 16'd21, 2'b11, 16'h2222, q, f, lat, rc);
    @(negedge clk); #1;
    n0 = mdl[0].rdy_cnt;
    en[0] = 1'b1; rw[0] = WR; addr[0] = 16'd20; be[0] = 2'b11; wd[0] = 16'h1111; drv[0] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk); #1;
      if (rdy[0]) seen = 1'b1;
      else addr[0] = addr[0] + 16'd1;
    end
    en[0] = 1'b0; drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_ready_pulses", mdl[0].rdy_cnt - n0, 1);
    req(0, 0, RD, 16'd20, 2'b00, 16'h0, q, f, lat, rc);
    chk("t5_word20", q, 16'h1111);
    req(0, 0, RD, 16'd21, 2'b00, 16'h0, q, f, lat, rc);
    chk("t5_word21", q, 16'h2222);

    // 6: reset during WAIT of a write
    req(0, 1, WR, 16'd9, 2'b11, 16'h0001, q, f, lat, rc);
    @(negedge clk); #1;
    n0 = mdl[0].rdy_cnt;
    en[0] = 1'b1; rw[0] = WR; addr[0] = 16'd9; be[0] = 2'b11; wd[0] = 16'hFFFF; drv[0] = 1'b1;
    @(negedge clk); #1;
    rst[0] = 1'b1; en[0] = 1'b0; drv[0] = 1'b0;
    @(negedge clk); #1;
    chk("t6_bus_in_reset", bus0, 16'hFFFF);
    rst[0] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t6_no_ready", mdl[0].rdy_cnt - n0, 0);
    req(0, 0, RD, 16'd9, 2'b00, 16'h0, q, f, lat, rc);
    chk("t6_word9", q, 16'h0001);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
